nanov_reg_sequencer: RTL

Pass controller for the nanoV bit-serial register file. Accepts one register-access request at a time and drives the file's `pause`, `wr_en`, `rs1`, `rs2` and `rd` inputs through exactly 32 unpaused cycles. It emits per-bit alignment flags so the serial ALU knows which bit is on `data_rs1`/`data_rs2` and when to drive `data_rd`. It sits between instruction decode and the register file, and it keeps the file's free-running bit pointers aligned to bit 0 at every pass boundary.

---
 rtl/nanov_reg_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/nanov_reg_sequencer.sv
// rtl/nanov_reg_sequencer.sv - pass controller for the nanoV bit-serial register file
//
// Runs one register-access pass at a time. A pass is exactly 32 unpaused
// cycles, so the register file's free-running bit pointers are back at bit 0
// whenever a new pass starts.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request valid, taken only while ready=1
//   req_rs1/req_rs2/req_rd   request register indices
//   req_wr                   request writes req_rd
//   hold                     external stall, freezes a running pass
//   ready                    idle, the next start is accepted
//   pause, wr_en             register file pause / write enable
//   rs1, rs2, rd             register file indices, held until the next request
//   bit_valid, bit_idx       fresh operand bit on the file outputs and its index
//   first_bit, last_bit      bit_valid qualified with bit_idx==0 / ==31
//   done                     one-cycle pulse on the final write cycle
module nanov_reg_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] req_rs1,
    input  logic [3:0] req_rs2,
    input  logic [3:0] req_rd,
    input  logic       req_wr,
    input  logic       hold,
    output logic       ready,
    output logic       pause,
    output logic       wr_en,
    output logic [3:0] rs1,
    output logic [3:0] rs2,
    output logic [3:0] rd,
    output logic       bit_valid,
    output logic [4:0] bit_idx,
    output logic       first_bit,
    output logic       last_bit,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] rcnt;
    logic       wr_q;
    logic       bv_q;
    logic [4:0] idx_q;

    // A bit is read from the file in every unpaused RUN cycle.
    logic step;
    assign step = (state == S_RUN) && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rcnt  <= 5'd0;
            wr_q  <= 1'b0;
            bv_q  <= 1'b0;
            idx_q <= 5'd0;
            rs1   <= 4'd0;
            rs2   <= 4'd0;
            rd    <= 4'd0;
        end else begin
            // The bit read this cycle is presented by the file next cycle,
            // so the valid flag and index trail the read counter by one.
            bv_q <= step;
            if (step) begin
                idx_q <= rcnt;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rs1   <= req_rs1;
                        rs2   <= req_rs2;
                        rd    <= req_rd;
                        // x0 is hardwired; never write it.
                        wr_q  <= req_wr && (req_rd != 4'd0);
                        rcnt  <= 5'd0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        rcnt <= rcnt + 5'd1;
                        if (rcnt == 5'd31) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Bit 31 is written this cycle; the file is paused.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // While reset is asserted the outputs already show the idle values, so a
    // pass abandoned by reset cannot write in the reset cycle.
    assign ready     = rst || (state == S_IDLE);
    assign pause     = rst || (state != S_RUN) || hold;
    assign bit_valid = !rst && bv_q;
    assign bit_idx   = idx_q;
    assign wr_en     = bit_valid && wr_q;
    assign first_bit = bit_valid && (idx_q == 5'd0);
    assign last_bit  = bit_valid && (idx_q == 5'd31);
    assign done      = !rst && (state == S_DRAIN);

endmodule
